// File: rtl/alu_exec_pkg.sv
// Shared widths, ALU operation codes and the FIFO entry payload for the ALU execution stage.
package alu_exec_pkg;

  localparam int unsigned ALU_WORD_W = 16;
  localparam int unsigned ALU_TAG_W  = 4;
  localparam int unsigned ALU_CODE_W = 4;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD      = 4'b0000;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB      = 4'b0001;
  localparam logic [ALU_CODE_W-1:0] ALU_AND      = 4'b0010;
  localparam logic [ALU_CODE_W-1:0] ALU_ORR      = 4'b0011;
  localparam logic [ALU_CODE_W-1:0] ALU_NOT      = 4'b0100;
  localparam logic [ALU_CODE_W-1:0] ALU_TCP      = 4'b0101;
  localparam logic [ALU_CODE_W-1:0] ALU_SHL      = 4'b0110;
  localparam logic [ALU_CODE_W-1:0] ALU_SHR      = 4'b0111;
  localparam logic [ALU_CODE_W-1:0] ALU_LHI      = 4'b1000;
  localparam logic [ALU_CODE_W-1:0] ALU_TST      = 4'b1001;
  localparam logic [ALU_CODE_W-1:0] ALU_PASS     = 4'b1010;
  localparam logic [ALU_CODE_W-1:0] ALU_RSVD_MIN = 4'b1011;

  // One buffered result; zero/neg are not stored, they are derived from result.
  typedef struct packed {
    logic [ALU_WORD_W-1:0] result;
    logic [ALU_TAG_W-1:0]  tag;
    logic                  ovf;
    logic                  illegal;
  } alu_entry_t;

endpackage

// File: rtl/alu_exec_core.sv
// Purely combinational ALU: operation code and operands to result, signed overflow and reserved-code flag.
module alu_exec_core
  import alu_exec_pkg::*;
#(
  parameter int unsigned WORD_SIZE = ALU_WORD_W
) (
  input  logic [ALU_CODE_W-1:0] code,
  input  logic [WORD_SIZE-1:0]  a,
  input  logic [WORD_SIZE-1:0]  b,
  output logic [WORD_SIZE-1:0]  result,
  output logic                  ovf,
  output logic                  illegal
);

  localparam int unsigned MSB = WORD_SIZE - 1;

  always_comb begin
    result  = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (code)
      ALU_ADD: begin
        result = a + b;
        ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        result = a - b;
        ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_AND:  result = a & b;
      ALU_ORR:  result = a | b;
      ALU_NOT:  result = ~a;
      ALU_TCP:  result = '0 - a;
      ALU_SHL:  result = {a[MSB-1:0], 1'b0};
      ALU_SHR:  result = {a[MSB], a[MSB:1]};
      ALU_LHI:  result = WORD_SIZE'({b[7:0], 8'h00});
      ALU_TST:  result = a;
      ALU_PASS: result = a;
      // Reserved codes still produce an entry so the tag comes back to the issuer.
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Registered, back-pressurable ALU stage: valid/ready request in, 2-entry in-order result FIFO out.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int unsigned WORD_SIZE = ALU_WORD_W,
  parameter int unsigned TAG_W     = ALU_TAG_W,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CODE_W-1:0] in_code,
  input  logic [WORD_SIZE-1:0]  in_a,
  input  logic [WORD_SIZE-1:0]  in_b,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_SIZE-1:0]  out_result,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_zero,
  output logic                  out_neg,
  output logic                  out_ovf,
  output logic                  out_illegal
);

  localparam int unsigned CNT_W = 2;

  logic [CNT_W-1:0]     count_q, count_d;
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  alu_entry_t           mem_q [DEPTH];
  alu_entry_t           mem_d [DEPTH];
  alu_entry_t           new_entry;
  alu_entry_t           head_entry;
  logic [WORD_SIZE-1:0] core_result;
  logic                 core_ovf;
  logic                 core_illegal;
  logic                 push;
  logic                 pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  alu_exec_core #(
    .WORD_SIZE (WORD_SIZE)
  ) u_core (
    .code    (in_code),
    .a       (in_a),
    .b       (in_b),
    .result  (core_result),
    .ovf     (core_ovf),
    .illegal (core_illegal)
  );

  always_comb begin
    new_entry         = '0;
    new_entry.result  = core_result;
    new_entry.tag     = in_tag;
    new_entry.ovf     = core_ovf;
    new_entry.illegal = core_illegal;
  end

  // Next FIFO state; the output registers are loaded from the next head entry.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[tail_q] = new_entry;
    end
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    head_d     = head_q ^ pop;
    tail_d     = tail_q ^ push;
    head_entry = mem_d[head_d];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_zero    <= 1'b0;
      out_neg     <= 1'b0;
      out_ovf     <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      mem_q       <= mem_d;
      // in_ready reflects occupancy only, so a full FIFO never bypasses even when popping.
      in_ready    <= (count_d < CNT_W'(DEPTH));
      out_valid   <= (count_d != '0);
      out_result  <= head_entry.result;
      out_tag     <= head_entry.tag;
      out_zero    <= (head_entry.result == '0);
      out_neg     <= head_entry.result[WORD_SIZE-1];
      out_ovf     <= head_entry.ovf;
      out_illegal <= head_entry.illegal;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vectors, back-pressure, throughput, random traffic and reset.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_code;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_tag;
  logic        out_zero;
  logic        out_neg;
  logic        out_ovf;
  logic        out_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  tag;
    logic        ovf;
    logic        ill;
  } entry_t;

  entry_t     mq[$];
  logic [3:0] popped[$];

  alu_exec dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_code     (in_code),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .out_ovf     (out_ovf),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  // Reference ALU from the operation table, using signed integer arithmetic.
  function automatic entry_t model(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] t);
    entry_t e;
    int sa, sb, s;
    sa    = int'($signed(a));
    sb    = int'($signed(b));
    e.tag = t;
    e.ovf = 1'b0;
    e.ill = 1'b0;
    case (c)
      4'd0:  begin s = sa + sb; e.r = 16'(s); e.ovf = (s > 32767) || (s < -32768); end
      4'd1:  begin s = sa - sb; e.r = 16'(s); e.ovf = (s > 32767) || (s < -32768); end
      4'd2:  e.r = a & b;
      4'd3:  e.r = a | b;
      4'd4:  e.r = ~a;
      4'd5:  e.r = 16'(0 - sa);
      4'd6:  e.r = 16'(sa * 2);
      4'd7:  e.r = 16'(sa >>> 1);
      4'd8:  e.r = 16'(int'(b[7:0]) * 256);
      4'd9:  e.r = a;
      4'd10: e.r = a;
      default: begin e.r = 16'h0000; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic logic [23:0] exp_out();
    entry_t e;
    e = mq[0];
    return {e.r, e.tag, (e.r == 16'h0000), e.r[15], e.ovf, e.ill};
  endfunction

  function automatic logic [23:0] act_out();
    return {out_result, out_tag, out_zero, out_neg, out_ovf, out_illegal};
  endfunction

  // Advance one clock, updating the model with what the handshakes transferred.
  task automatic step(output bit acc);
    bit pop;
    acc = (in_valid === 1'b1) && (in_ready === 1'b1);
    pop = (out_valid === 1'b1) && (out_ready === 1'b1);
    if (pop) begin
      popped.push_back(out_tag);
      if (mq.size() != 0) void'(mq.pop_front());
    end
    if (acc) mq.push_back(model(in_code, in_a, in_b, in_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    in_code = 4'($urandom_range(0, 15));
    in_a    = 16'($urandom);
    in_b    = 16'($urandom);
    in_tag  = 4'($urandom);
  endtask

  task automatic test_reset();
    bit acc;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_code   = 4'h0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    in_tag    = 4'h0;
    #2;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_result !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_hold: valid=%b ready=%b result=%h required 0 0 0000", out_valid, in_ready, out_result);
    end
    #10 reset_n = 1'b1;
    step(acc);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 16'h0 || out_tag !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_release: ready=%b valid=%b result=%h tag=%h required 1 0 0000 0",
               in_ready, out_valid, out_result, out_tag);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  vc[9] = '{4'h0, 4'h1, 4'h5, 4'h7, 4'h6, 4'h8, 4'hC, 4'h9, 4'h9};
    logic [15:0] va[9] = '{16'h7FFF, 16'h0005, 16'h0001, 16'h8002, 16'h8001, 16'h1234, 16'h5555, 16'hFFFE, 16'h0000};
    logic [15:0] vb[9] = '{16'h0001, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h00AB, 16'h3333, 16'h0000, 16'h0000};
    logic [3:0]  vt[9] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    logic [15:0] er[9] = '{16'h8000, 16'h0000, 16'hFFFF, 16'hC001, 16'h0002, 16'hAB00, 16'h0000, 16'hFFFE, 16'h0000};
    logic [3:0]  ef[9] = '{4'b0110, 4'b1000, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b1001, 4'b0100, 4'b1000};
    bit acc;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_code  = vc[i];
      in_a     = va[i];
      in_b     = vb[i];
      in_tag   = vt[i];
      step(acc);
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_result !== er[i] || out_tag !== vt[i] ||
          {out_zero, out_neg, out_ovf, out_illegal} !== ef[i]) begin
        n_bad++;
        $display("FAIL directed_%0d: valid=%b result=%h tag=%h zno_i=%b required 1 %h %h %b",
                 i, out_valid, out_result, out_tag, {out_zero, out_neg, out_ovf, out_illegal}, er[i], vt[i], ef[i]);
      end
      n_cmp++;
      if (mq.size() == 0 || act_out() !== exp_out()) begin
        n_bad++;
        $display("FAIL directed_model_%0d: got %h required %h", i, act_out(), (mq.size() != 0) ? exp_out() : 24'h0);
      end
      step(acc);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL directed_drain_%0d: valid=%b required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_pressure();
    bit acc;
    bit got3 = 1'b0;
    popped.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int t = 1; t <= 2; t++) begin
      in_code = 4'h0;
      in_a    = 16'(t * 100);
      in_b    = 16'h0001;
      in_tag  = 4'(t);
      step(acc);
    end
    in_tag = 4'd3;
    in_a   = 16'd300;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'd1 || out_result !== 16'd101) begin
        n_bad++;
        $display("FAIL bp_stall_%0d: ready=%b valid=%b tag=%h result=%h required 0 1 1 0065",
                 c, in_ready, out_valid, out_tag, out_result);
      end
      step(acc);
      if (acc) got3 = 1'b1;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && !got3; c++) begin
      step(acc);
      if (acc) got3 = 1'b1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!got3) begin
      n_bad++;
      $display("FAIL bp_accept3: tag 3 accepted=0 required 1");
    end
    for (int c = 0; c < 10 && mq.size() != 0; c++) step(acc);
    n_cmp++;
    if (popped.size() != 3 || popped[0] !== 4'd1 || popped[1] !== 4'd2 || popped[2] !== 4'd3) begin
      n_bad++;
      $display("FAIL bp_order: popped %0d tags %p required tags 1,2,3", popped.size(), popped);
    end
  endtask

  task automatic test_throughput();
    bit acc;
    logic [3:0] issued[$];
    popped.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      drive_rand();
      in_tag = 4'(c + 8);
      issued.push_back(in_tag);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL tp_ready_%0d: ready=%b required 1", c, in_ready);
      end
      step(acc);
      n_cmp++;
      if (out_valid !== 1'b1 || mq.size() == 0 || act_out() !== exp_out()) begin
        n_bad++;
        $display("FAIL tp_out_%0d: valid=%b got %h required 1 %h", c, out_valid, act_out(),
                 (mq.size() != 0) ? exp_out() : 24'h0);
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 10 && mq.size() != 0; c++) step(acc);
    n_cmp++;
    if (popped.size() != 8 || popped != issued) begin
      n_bad++;
      $display("FAIL tp_order: popped %p required %p", popped, issued);
    end
  endtask

  task automatic test_random();
    bit acc;
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      drive_rand();
      #1;
      n_cmp++;
      if (in_ready !== (mq.size() < 2) || out_valid !== (mq.size() != 0)) begin
        n_bad++;
        $display("FAIL rand_hs_%0d: ready=%b valid=%b required %b %b", c, in_ready, out_valid,
                 mq.size() < 2, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        n_cmp++;
        if (act_out() !== exp_out()) begin
          n_bad++;
          $display("FAIL rand_out_%0d: got %h required %h", c, act_out(), exp_out());
        end
      end
      step(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && mq.size() != 0; c++) step(acc);
    n_cmp++;
    if (out_valid !== 1'b0 || mq.size() != 0) begin
      n_bad++;
      $display("FAIL rand_drain: valid=%b model_left=%0d required 0 0", out_valid, mq.size());
    end
  endtask

  task automatic test_reset_midstream();
    bit acc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive_rand();
      in_code = 4'h2;
      in_a    = 16'hFFFF;
      in_b    = 16'h1234;
      step(acc);
    end
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_full: ready=%b valid=%b required 0 1", in_ready, out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    mq.delete();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_result !== 16'h0) begin
      n_bad++;
      $display("FAIL mid_reset: valid=%b ready=%b result=%h required 0 0 0000", out_valid, in_ready, out_result);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    step(acc);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 16'h0 || out_tag !== 4'h0) begin
      n_bad++;
      $display("FAIL mid_release: ready=%b valid=%b result=%h tag=%h required 1 0 0000 0",
               in_ready, out_valid, out_result, out_tag);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_throughput();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
